// File: rtl/nfc_frame_scheduler.sv
// Buffers one parsed NFC frame, streams it to the TX framer, then waits for the
// RX response (or timeout) and holds a guard gap before accepting the next frame.
module nfc_frame_scheduler #(
  parameter int MAX_LEN     = 64,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int GAP_CYC     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_tvalid,
  input  logic [7:0] in_tdata,
  input  logic [3:0] in_tdatab,
  input  logic       in_tlast,
  output logic       tx_tvalid,
  input  logic       tx_tready,
  output logic [7:0] tx_tdata,
  output logic [3:0] tx_tdatab,
  output logic       tx_tlast,
  input  logic       rx_done,
  output logic       busy,
  output logic       resp_ok,
  output logic       timeout,
  output logic       ovf,
  output logic       drop
);

  // state   | meaning
  // COLLECT | accepting bytes of the next frame into the buffer
  // SEND    | streaming the buffered frame to the TX framer
  // WAIT_RX | waiting for rx_done or the response timeout
  // GAP     | inter-frame guard interval
  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] WAIT_RX = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [CW-1:0] LEN_MAX  = CW'(MAX_LEN);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [3:0]    lastb_q, lastb_d;
  logic          ovf_flag_q, ovf_flag_d;
  logic          disc_q, disc_d;
  logic          prime_q, prime_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [3:0]    tx_datab_q, tx_datab_d;
  logic          tx_last_q, tx_last_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic          resp_ok_q, resp_ok_d;
  logic          timeout_q, timeout_d;
  logic          ovf_q, ovf_d;
  logic          drop_q, drop_d;
  logic          rx_exit;
  logic          mem_we;
  logic [7:0]    mem_q [MAX_LEN];

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    len_d      = len_q;
    rptr_d     = rptr_q;
    lastb_d    = lastb_q;
    ovf_flag_d = ovf_flag_q;
    disc_d     = disc_q;
    prime_d    = prime_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_datab_d = tx_datab_q;
    tx_last_d  = tx_last_q;
    tmr_d      = tmr_q;
    gcnt_d     = gcnt_q;
    resp_ok_d  = 1'b0;
    timeout_d  = 1'b0;
    ovf_d      = 1'b0;
    drop_d     = 1'b0;
    rx_exit    = 1'b0;
    mem_we     = 1'b0;

    // Anything arriving while busy with a previous frame is swallowed whole.
    if (state_q != COLLECT && in_tvalid) begin
      if (in_tlast) begin
        drop_d = 1'b1;
        disc_d = 1'b0;
      end else begin
        disc_d = 1'b1;
      end
    end

    case (state_q)
      COLLECT: begin
        if (in_tvalid) begin
          if (disc_q) begin
            if (in_tlast) begin
              drop_d = 1'b1;
              disc_d = 1'b0;
            end
          end else if (in_tlast) begin
            if (ovf_flag_q || wcnt_q == LEN_MAX) begin
              ovf_d      = 1'b1;
              wcnt_d     = '0;
              ovf_flag_d = 1'b0;
            end else begin
              mem_we  = 1'b1;
              len_d   = wcnt_q + 1'b1;
              lastb_d = (in_tdatab == 4'd0 || in_tdatab > 4'd8) ? 4'd8 : in_tdatab;
              rptr_d  = '0;
              prime_d = 1'b1;
              state_d = SEND;
            end
          end else if (wcnt_q == LEN_MAX) begin
            ovf_flag_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      SEND: begin
        if (prime_q) begin
          prime_d = 1'b0;
        end else if (!tx_valid_q || tx_tready) begin
          if (tx_valid_q && tx_last_q) begin
            tx_valid_d = 1'b0;
            tmr_d      = '0;
            state_d    = WAIT_RX;
          end else if (rptr_q != len_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = mem_q[rptr_q[AW-1:0]];
            tx_last_d  = (rptr_q == len_q - 1'b1);
            tx_datab_d = (rptr_q == len_q - 1'b1) ? lastb_q : 4'd8;
            rptr_d     = rptr_q + 1'b1;
          end else begin
            tx_valid_d = 1'b0;
          end
        end
      end
      WAIT_RX: begin
        if (rx_done) begin
          resp_ok_d = 1'b1;
          rx_exit   = 1'b1;
        end else if (tmr_q == TMR_LAST) begin
          timeout_d = 1'b1;
          rx_exit   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d    = COLLECT;
          wcnt_d     = '0;
          ovf_flag_d = 1'b0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase

    // A zero-length guard skips GAP entirely.
    if (rx_exit) begin
      if (GAP_CYC == 0) begin
        state_d    = COLLECT;
        wcnt_d     = '0;
        ovf_flag_d = 1'b0;
      end else begin
        state_d = GAP;
        gcnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      wcnt_q     <= '0;
      len_q      <= '0;
      rptr_q     <= '0;
      lastb_q    <= 4'd8;
      ovf_flag_q <= 1'b0;
      disc_q     <= 1'b0;
      prime_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_datab_q <= 4'd8;
      tx_last_q  <= 1'b0;
      tmr_q      <= '0;
      gcnt_q     <= '0;
      resp_ok_q  <= 1'b0;
      timeout_q  <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      len_q      <= len_d;
      rptr_q     <= rptr_d;
      lastb_q    <= lastb_d;
      ovf_flag_q <= ovf_flag_d;
      disc_q     <= disc_d;
      prime_q    <= prime_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_datab_q <= tx_datab_d;
      tx_last_q  <= tx_last_d;
      tmr_q      <= tmr_d;
      gcnt_q     <= gcnt_d;
      resp_ok_q  <= resp_ok_d;
      timeout_q  <= timeout_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wcnt_q[AW-1:0]] <= in_tdata;
    end
  end

  assign tx_tvalid = tx_valid_q;
  assign tx_tdata  = tx_data_q;
  assign tx_tdatab = tx_datab_q;
  assign tx_tlast  = tx_last_q;
  assign busy      = !(state_q == COLLECT && wcnt_q == '0);
  assign resp_ok   = resp_ok_q;
  assign timeout   = timeout_q;
  assign ovf       = ovf_q;
  assign drop      = drop_q;

endmodule
